// File: rtl/noun_loader_pkg.sv
// rtl/noun_loader_pkg.sv - shared widths, memory write code and loader state encoding
package noun_loader_pkg;

    localparam int MEMORY_ADDR_WIDTH = 10;
    localparam int MEMORY_DATA_WIDTH = 16;

    localparam logic [1:0] MEM_FUNC_WRITE = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_START     = 3'd5,
        ST_RUN       = 3'd6,
        ST_ERR       = 3'd7
    } loader_state_t;

endpackage

// File: rtl/noun_loader_ack_timer.sv
// rtl/noun_loader_ack_timer.sv - per-phase memory acknowledge timeout counter
module loader_ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count;

    // count holds k-1 during the k-th cycle after a load, saturating at LAST
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/noun_loader.sv
// rtl/noun_loader.sv - streams a noun image into memory, then launches and waits for traversal
module noun_loader
    import noun_loader_pkg::*;
#(
    parameter int MAX_WORDS   = 1024,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [MEMORY_ADDR_WIDTH-1:0] base_addr,
    input  logic [MEMORY_ADDR_WIDTH-1:0] root_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MEMORY_DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    input  logic                         mem_ready,
    output logic                         mem_execute,
    output logic [1:0]                   mem_func,
    output logic [MEMORY_ADDR_WIDTH-1:0] address,
    output logic [MEMORY_DATA_WIDTH-1:0] write_data,
    output logic                         bus_sel,
    output logic [MEMORY_ADDR_WIDTH-1:0] trav_start_addr,
    output logic                         trav_execute,
    input  logic                         trav_finished,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [MEMORY_ADDR_WIDTH:0]   word_count
);

    localparam int WCW = MEMORY_ADDR_WIDTH + 1;

    loader_state_t                state;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_ptr;
    logic [MEMORY_ADDR_WIDTH-1:0] root_q;
    logic                         last_q;
    logic                         addr_wrapped;
    logic                         tmr_load;
    logic                         tmr_expired;

    // restart the timer on every entry into WAIT_BUSY (from ISSUE) and WAIT_DONE
    assign tmr_load = (state == ST_ISSUE) || (state == ST_WAIT_BUSY && !mem_ready);

    loader_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            in_ready        <= 1'b0;
            mem_execute     <= 1'b0;
            mem_func        <= 2'b00;
            address         <= '0;
            write_data      <= '0;
            bus_sel         <= 1'b0;
            trav_start_addr <= '0;
            trav_execute    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            word_count      <= '0;
            addr_ptr        <= '0;
            root_q          <= '0;
            last_q          <= 1'b0;
            addr_wrapped    <= 1'b0;
        end else begin
            mem_execute <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state        <= ST_ACCEPT;
                        busy         <= 1'b1;
                        bus_sel      <= 1'b1;
                        in_ready     <= 1'b1;
                        word_count   <= '0;
                        addr_ptr     <= base_addr;
                        root_q       <= root_addr;
                        addr_wrapped <= 1'b0;
                        mem_func     <= MEM_FUNC_WRITE;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        // a word that would exceed the budget or wrap the address space is dropped
                        if (word_count == WCW'(MAX_WORDS) || addr_wrapped) begin
                            state <= ST_ERR;
                        end else begin
                            write_data <= in_data;
                            last_q     <= in_last;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_execute <= 1'b1;
                        address     <= addr_ptr;
                        state       <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!mem_ready) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmr_expired) begin
                        state <= ST_ERR;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mem_ready) begin
                        word_count <= word_count + 1'b1;
                        addr_ptr   <= addr_ptr + 1'b1;
                        if (addr_ptr == '1) begin
                            addr_wrapped <= 1'b1;
                        end
                        if (last_q) begin
                            bus_sel <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_ACCEPT;
                        end
                    end else if (tmr_expired) begin
                        state <= ST_ERR;
                    end
                end
                ST_START: begin
                    trav_start_addr <= root_q;
                    trav_execute    <= 1'b1;
                    state           <= ST_RUN;
                end
                ST_RUN: begin
                    if (trav_finished) begin
                        trav_execute <= 1'b0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    bus_sel <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noun_loader.sv
// tb/tb_noun_loader.sv - directed checks of noun_loader against a memory and traversal model
module tb_noun_loader;
    import noun_loader_pkg::*;

    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int DW = MEMORY_DATA_WIDTH;
    localparam logic [DW-1:0] SENT = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] root_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          mem_ready;
    logic          mem_execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic          bus_sel;
    logic [AW-1:0] trav_start_addr;
    logic          trav_execute;
    logic          trav_finished;
    logic          busy, done, error;
    logic [AW:0]   word_count;

    noun_loader #(.MAX_WORDS(4), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .root_addr(root_addr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mem_ready(mem_ready),
        .mem_execute(mem_execute), .mem_func(mem_func), .address(address),
        .write_data(write_data), .bus_sel(bus_sel), .trav_start_addr(trav_start_addr),
        .trav_execute(trav_execute), .trav_finished(trav_finished), .busy(busy),
        .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // memory model: drops ready on a request, holds it low stall_cfg cycles (or forever when hang)
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          mem_busy;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    int            stall, stall_cfg = 0;
    bit            hang = 0;

    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b1;
            mem_busy  <= 1'b0;
            stall     <= 0;
        end else if (mem_busy) begin
            if (stall > 0) begin
                stall <= stall - 1;
            end else if (!hang) begin
                ram[lat_addr] <= lat_data;
                mem_ready     <= 1'b1;
                mem_busy      <= 1'b0;
            end
        end else if (mem_execute && mem_ready) begin
            mem_busy  <= 1'b1;
            mem_ready <= 1'b0;
            lat_addr  <= address;
            lat_data  <= write_data;
            stall     <= stall_cfg;
        end
    end

    // traversal model: finishes four cycles after execute rises
    int            tcnt;
    logic [AW-1:0] trav_seen;
    always @(posedge clk) begin
        if (rst) begin
            trav_finished <= 1'b0;
            tcnt          <= 0;
            trav_seen     <= '0;
        end else begin
            trav_finished <= 1'b0;
            if (trav_execute && !trav_finished) begin
                if (tcnt == 3) begin
                    trav_finished <= 1'b1;
                    tcnt          <= 0;
                    trav_seen     <= trav_start_addr;
                end else begin
                    tcnt <= tcnt + 1;
                end
            end
        end
    end

    int exec_cnt = 0, ready_viol = 0, overlap = 0, bad_func = 0;
    always @(negedge clk) begin
        if (mem_execute) exec_cnt++;
        if (mem_execute && mem_func != MEM_FUNC_WRITE) bad_func++;
        if (in_ready && (mem_execute || mem_busy || trav_execute)) ready_viol++;
        if (bus_sel && trav_execute) overlap++;
    end

    int pass_cnt = 0, total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] word_of(input int t, input int i);
        return DW'(t * 256 + i + 17);
    endfunction

    task automatic start_load(input logic [AW-1:0] b, input logic [AW-1:0] r);
        @(negedge clk);
        base_addr  = b;
        root_addr  = r;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic l, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            in_data  = d;
            in_last  = l;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ok = in_valid && in_ready;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push_image(input int t, input int n, input int last_at, input bit rnd, input string tag);
        bit ok;
        int acc = 0;
        for (int i = 0; i < n; i++) begin
            push_word(word_of(t, i), 1'(i == last_at), rnd, ok);
            if (ok) acc++;
        end
        check({tag, "_accepted"}, acc, n);
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int c = 0; c < budget && !got_done && !got_err; c++) begin
            @(negedge clk);
            got_done = done;
            got_err  = error;
        end
    endtask

    task automatic check_ram(input logic [AW-1:0] b, input int t, input int n, input string tag);
        for (int i = 0; i < n; i++) check({tag, "_ram"}, ram[AW'(b + i)], word_of(t, i));
    endtask

    bit got_done, got_err, saw;
    int e0, cyc;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = SENT;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_bus_sel", bus_sel, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_exec", mem_execute, 0);
        check("rst_trav_exec", trav_execute, 0);
        check("rst_word_count", word_count, 0);
        check("rst_status", {done, error, mem_func}, 0);
        rst = 1'b0;

        // basic 4-word load at base 1, root 1
        e0 = exec_cnt;
        start_load(10'd1, 10'd1);
        check("t1_in_ready", in_ready, 1);
        check("t1_busy", busy, 1);
        push_image(1, 4, 3, 0, "t1");
        wait_end(200, got_done, got_err);
        check("t1_done", {got_done, got_err}, 2'b10);
        check_ram(10'd1, 1, 4, "t1");
        check("t1_word_count", word_count, 4);
        check("t1_trav_addr", trav_seen, 1);
        check("t1_execs", exec_cnt - e0, 4);
        @(negedge clk);
        check("t1_idle", {busy, bus_sel, trav_execute, done}, 0);

        // random valid gaps
        start_load(10'd20, 10'd7);
        push_image(2, 4, 3, 1, "t2");
        wait_end(200, got_done, got_err);
        check("t2_done", {got_done, got_err}, 2'b10);
        check_ram(10'd20, 2, 4, "t2");
        check("t2_trav_addr", trav_seen, 7);

        // memory stalls 10 cycles per write
        stall_cfg = 10;
        e0 = exec_cnt;
        start_load(10'd40, 10'd40);
        push_image(3, 3, 2, 0, "t3");
        wait_end(300, got_done, got_err);
        check("t3_done", {got_done, got_err}, 2'b10);
        check_ram(10'd40, 3, 3, "t3");
        check("t3_execs", exec_cnt - e0, 3);
        check("t3_word_count", word_count, 3);
        stall_cfg = 0;

        // ack never returns: timeout 255 cycles into WAIT_DONE
        hang = 1;
        start_load(10'd60, 10'd0);
        push_image(4, 1, 0, 0, "t4");
        saw = 0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge clk);
            saw = mem_execute;
        end
        check("t4_exec_seen", saw, 1);
        cyc = 0;
        got_err = 0;
        for (int c = 0; c < 400 && !got_err; c++) begin
            @(negedge clk);
            cyc++;
            got_err = error;
        end
        // 1 exec cycle + 1 ready-drop cycle + 255 WAIT_DONE + 1 ERR
        check("t4_err_latency", cyc, 258);
        check("t4_after_err", {bus_sel, busy}, 0);
        check("t4_word_count", word_count, 0);
        @(negedge clk);
        check("t4_err_pulse", error, 0);
        hang = 0;
        repeat (3) @(negedge clk);

        // fifth word overflows the 4-word budget
        e0 = exec_cnt;
        start_load(10'd100, 10'd0);
        push_image(5, 5, 4, 0, "t5");
        wait_end(50, got_done, got_err);
        check("t5_err", {got_done, got_err}, 2'b01);
        check("t5_word_count", word_count, 4);
        check_ram(10'd100, 5, 4, "t5");
        check("t5_untouched", ram[104], SENT);
        check("t5_execs", exec_cnt - e0, 4);

        // address wrap past the top of memory
        start_load(10'd1022, 10'd3);
        push_image(6, 3, 2, 0, "t6");
        wait_end(50, got_done, got_err);
        check("t6_err", {got_done, got_err}, 2'b01);
        check("t6_word_count", word_count, 2);
        check_ram(10'd1022, 6, 2, "t6");
        check("t6_no_wrap_write", ram[0], SENT);

        // reset while waiting on the memory ack, then a clean reload
        start_load(10'd200, 10'd5);
        push_image(7, 1, 0, 0, "t7");
        saw = 0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge clk);
            saw = mem_execute;
        end
        check("t7_exec_seen", saw, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_outputs", {busy, bus_sel, in_ready, mem_execute, trav_execute, done, error}, 0);
        check("t7_rst_word_count", word_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_no_write", ram[200], SENT);
        start_load(10'd200, 10'd5);
        push_image(8, 2, 1, 0, "t7b");
        wait_end(200, got_done, got_err);
        check("t7_done", {got_done, got_err}, 2'b10);
        check_ram(10'd200, 8, 2, "t7");
        check("t7_trav_addr", trav_seen, 5);

        check("in_ready_outside_accept", ready_viol, 0);
        check("bus_overlap", overlap, 0);
        check("mem_func_write", bad_func, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
